// File: rtl/cobi_arb_pkg.sv
// cobi_arb_pkg: shared state type and modulo-increment helper for the round-robin arbiter.
package cobi_arb_pkg;
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
    function automatic int rr_next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational rotating-priority pick of the first request at or after ptr.
module rr_priority_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [N-1:0] masked;
    logic [N-1:0] src;
    always_comb begin
        masked = '0;
        for (int k = 0; k < N; k++) masked[k] = req[k] && (k >= int'(ptr));
        // Requests at or above ptr win; otherwise wrap to the unmasked set.
        src = |masked ? masked : req;
        any = |req;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) if (src[k]) idx = W'(k);
        onehot = any ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: N-way round-robin arbiter with registered held grants and hold-limit preemption.
module rr_hold_arbiter import cobi_arb_pkg::*; #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             en,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             preempt_o
);
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt, idx_nxt, nxt_ptr, pick_ptr, pick_idx;
    logic [CNT_W-1:0] hold_cnt, cnt_nxt;
    logic [N_REQ-1:0] gnt_nxt, others, pick_req, pick_oh;
    logic             pick_any, rel_done, timeout, release_g, preempt_nxt, granting;
    assign others   = req_i & ~gnt_o;
    assign granting = (state == ARB_GRANT);
    assign nxt_ptr  = IDX_W'(rr_next_idx(int'(gnt_idx_o), N_REQ));
    assign rel_done = done_i || !(|(req_i & gnt_o));
    assign timeout  = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1)) && (|others);
    assign release_g = granting && (rel_done || timeout);
    // On release the holder is excluded and priority already starts after it.
    assign pick_req = granting ? others : req_i;
    assign pick_ptr = granting ? nxt_ptr : ptr;
    rr_priority_pick #(.N(N_REQ), .W(IDX_W)) u_pick (
        .req(pick_req), .ptr(pick_ptr), .onehot(pick_oh), .idx(pick_idx), .any(pick_any)
    );
    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt_o;
        idx_nxt     = gnt_idx_o;
        ptr_nxt     = ptr;
        cnt_nxt     = granting && (hold_cnt != CNT_W'(MAX_HOLD)) ? hold_cnt + 1'b1 : hold_cnt;
        preempt_nxt = release_g && !rel_done;
        if (!granting && en && pick_any) begin
            state_nxt = ARB_GRANT;
            gnt_nxt   = pick_oh;
            idx_nxt   = pick_idx;
            cnt_nxt   = '0;
        end else if (release_g) begin
            ptr_nxt   = nxt_ptr;
            cnt_nxt   = '0;
            state_nxt = (en && pick_any) ? ARB_GRANT : ARB_IDLE;
            gnt_nxt   = (en && pick_any) ? pick_oh : '0;
            idx_nxt   = (en && pick_any) ? pick_idx : gnt_idx_o;
        end
    end
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state     <= ARB_IDLE;
            gnt_o     <= '0;
            gnt_idx_o <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
            preempt_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt_o     <= gnt_nxt;
            gnt_idx_o <= idx_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= cnt_nxt;
            preempt_o <= preempt_nxt;
        end
    end
    assign gnt_valid_o = |gnt_o;
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb_rr_hold_arbiter: directed and random checks of rr_hold_arbiter against a holder/age model.
module tb_rr_hold_arbiter;
    localparam int N = 4;
    localparam int MAXH = 4;
    logic         clk = 1'b0;
    logic         resetb = 1'b0;
    logic         en = 1'b0;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_idx;
    logic         preempt;
    int errors = 0;
    int checks = 0;
    int m_h = -1;
    int m_ptr = 0;
    int m_age = 0;
    int m_idx = 0;
    bit m_pre = 1'b0;
    rr_hold_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .resetb(resetb), .en(en), .req_i(req), .done_i(done),
        .gnt_o(gnt), .gnt_valid_o(gnt_valid), .gnt_idx_o(gnt_idx), .preempt_o(preempt)
    );
    always #5 clk = ~clk;
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int j = 0; j < N; j++) if (r[(p + j) % N]) return (p + j) % N;
        return -1;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_h = -1; m_ptr = 0; m_age = 0; m_idx = 0; m_pre = 1'b0;
    endtask
    task automatic model_step();
        logic [N-1:0] oth;
        bit rel;
        int k;
        m_pre = 1'b0;
        if (m_h < 0) begin
            k = en ? pick(req, m_ptr) : -1;
            if (k >= 0) begin m_h = k; m_idx = k; m_age = 0; end
        end else begin
            oth = req & ~(N'(1) << m_h);
            rel = done || !req[m_h] || (m_age == MAXH - 1 && oth != 0);
            if (rel) begin
                m_pre = !done && req[m_h];
                m_ptr = (m_h + 1) % N;
                m_age = 0;
                k = en ? pick(oth, m_ptr) : -1;
                m_h = k;
                if (k >= 0) m_idx = k;
            end else if (m_age < MAXH) m_age++;
        end
    endtask
    task automatic check_all(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), m_h < 0 ? 32'd0 : 32'(1 << m_h));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(m_h >= 0));
        chk({tag, ".idx"}, 32'(gnt_idx), 32'(m_idx));
        chk({tag, ".preempt"}, 32'(preempt), 32'(m_pre));
        chk({tag, ".ptr"}, 32'(dut.ptr), 32'(m_ptr));
    endtask
    task automatic step(input string tag, input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            check_all(tag);
        end
    endtask
    initial begin
        #2;
        check_all("reset");
        @(negedge clk);
        resetb = 1'b1;
        en = 1'b1; req = 4'b1010;
        step("t1_grant");
        chk("t1_gnt_const", 32'(gnt), 32'h2);
        done = 1'b1;
        step("t1_done");
        chk("t1_next_const", 32'(gnt), 32'h8);
        chk("t1_ptr_const", 32'(dut.ptr), 32'd2);
        done = 1'b0; req = '0;
        step("t1_drop", 2);
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            done = (i % 2 == 1);
            step("t2_rr");
        end
        done = 1'b0; req = '0;
        step("t3_clear", 2);
        req = 4'b0011;
        step("t3_timeout", 7);
        req = 4'b0100;
        step("t4_single", 3);
        done = 1'b1;
        step("t4_done");
        done = 1'b0;
        step("t4_idle");
        step("t4_regrant", 8);
        chk("t4_hold_sat", 32'(dut.hold_cnt), 32'(m_age));
        chk("t4_hold_const", 32'(dut.hold_cnt), 32'd4);
        req = '0;
        step("t5_clear", 2);
        en = 1'b0; req = 4'b0100;
        step("t5_disabled", 3);
        en = 1'b1;
        step("t5_grant");
        en = 1'b0; req = 4'b0110;
        step("t5_hold", 3);
        done = 1'b1;
        step("t5_release");
        done = 1'b0;
        step("t5_after", 2);
        en = 1'b1; req = 4'b0010;
        step("t6_grant", 2);
        #2 resetb = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        req = 4'b1000;
        @(negedge clk);
        resetb = 1'b1;
        step("t6_post");
        chk("t6_gnt_const", 32'(gnt), 32'h8);
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
            done = ($urandom_range(0, 4) == 0);
            step("rand");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
